// File: rtl/imem_responder_pkg.sv
// Shared core constants for the instruction-memory responder.
//   NOP_WORD    : instruction returned for faulting fetches (addi x0,x0,0)
//   CNT_W       : width of the responder wait counter
//   rsp_state_e : responder FSM states
//   idx_width() : word-index width for a memory of a given depth
package imem_responder_pkg;

    localparam logic [31:0] NOP_WORD = 32'h00000013;
    localparam int          CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } rsp_state_e;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch bus between PC/fetch logic (master) and the instruction memory
// responder (slave), plus the program-load write port and redirect flush.
//   req_valid/req_ready/req_addr        : fetch request handshake
//   rsp_valid/rsp_ready/rsp_instr/rsp_err : fetch response handshake
//   flush                               : discard outstanding fetch
//   wr_en/wr_addr/wr_data               : program image load
interface imem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        flush;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport slave (
        input  req_valid, req_addr, rsp_ready, flush, wr_en, wr_addr, wr_data,
        output req_ready, rsp_valid, rsp_instr, rsp_err
    );

    modport master (
        output req_valid, req_addr, rsp_ready, flush, wr_en, wr_addr, wr_data,
        input  req_ready, rsp_valid, rsp_instr, rsp_err
    );
endinterface

// File: rtl/imem_responder_array.sv
// imem_array: synchronous word RAM, one read port and one write port.
// The read result is registered and held until the next read; a write to the
// same index in the read cycle is not visible to that read (read-before-write).
//   clk, rst            : clock, synchronous active-high reset (read register only)
//   rd_en, rd_idx       : read strobe and word index
//   rd_data             : registered read word (0 after reset)
//   wr_en, wr_idx, wr_data : write strobe, word index, data
module imem_array
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    localparam int         IDX_W       = idx_width(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rd_data_d, rd_data_q;

    // Contents are deliberately not reset: the program image survives rst.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = mem[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data_q <= '0;
        else     rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch address per handshake and
// returns the instruction WAIT_CYCLES+1 cycles after acceptance. Misaligned or
// out-of-range fetches return NOP_INSTR with rsp_err set.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch request/response, flush and program-load write port
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] NOP_INSTR   = NOP_WORD
) (
    input  logic               clk,
    input  logic               rst,
    imem_responder_if.slave    bus
);

    localparam int               IDX_W   = idx_width(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    rsp_state_e       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             rsp_err_d, rsp_err_q;

    logic        req_ready;
    logic        accept;
    logic        req_err;
    logic        wr_ok;
    logic [29:0] req_word;
    logic [29:0] wr_word;
    logic [31:0] rd_data;
    logic [1:0]  wr_unused;

    assign req_word  = bus.req_addr[31:2];
    assign wr_word   = bus.wr_addr[31:2];
    assign wr_unused = bus.wr_addr[1:0];

    assign req_err = (bus.req_addr[1:0] != 2'b00) || (req_word >= 30'(DEPTH_WORDS));
    assign wr_ok   = bus.wr_en && (wr_word < 30'(DEPTH_WORDS));

    assign req_ready = !rst && !bus.flush &&
                       (state_q == IDLE || (state_q == RESP && bus.rsp_ready));
    assign accept    = bus.req_valid && req_ready;

    // Faulting fetches skip the RAM read; the output mux substitutes the NOP,
    // so an out-of-range index never reaches the array.
    imem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_en   (accept && !req_err),
        .rd_idx  (req_word[IDX_W-1:0]),
        .rd_data (rd_data),
        .wr_en   (wr_ok),
        .wr_idx  (wr_word[IDX_W-1:0]),
        .wr_data (bus.wr_data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rsp_err_d = rsp_err_q;

        case (state_q)
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: ;
        endcase

        // Accept overrides the RESP->IDLE exit to give back-to-back issue.
        if (accept) begin
            rsp_err_d = req_err;
            if (WAIT_CYCLES == 0) begin
                state_d = RESP;
            end else begin
                state_d = WAIT;
                cnt_d   = WAIT_LD;
            end
        end

        if (bus.flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_instr = rsp_err_q ? NOP_INSTR : rd_data;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: table of single fetches plus
// hand-written sequences for back-to-back, backpressure, flush, same-cycle
// write and reset corner cases. A negedge monitor scoreboards every response.
module tb_imem_responder;
    import imem_responder_pkg::*;

    localparam int DEPTH = 1024;
    localparam int WAITC = 1;
    localparam int LAT   = WAITC + 1;
    localparam int IW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_responder_if bus();

    imem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC),
        .NOP_INSTR   (NOP_WORD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic        err;
        int          acc_cyc;
        bit          seen;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    exp_t        sb[$];
    logic [31:0] model_mem [DEPTH];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          hs_cnt = 0;
    int          last_hs_cyc = 0;
    int          last_acc_cyc = 0;
    logic [31:0] last_instr = '0;
    logic        last_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard monitor: order matters -- a handshake completes before flush
    // discards, and a new accept is pushed after the pop of the old response.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            sb.delete();
        end else begin
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_rsp_valid", 32'd1, 32'd0);
                end else begin
                    if (!sb[0].seen) begin
                        check("latency", 32'(cyc - sb[0].acc_cyc), 32'(LAT));
                        sb[0].seen = 1'b1;
                    end
                    check("rsp_instr", bus.rsp_instr, sb[0].instr);
                    check("rsp_err", 32'(bus.rsp_err), 32'(sb[0].err));
                    if (bus.rsp_ready) begin
                        hs_cnt++;
                        last_hs_cyc = cyc;
                        last_instr  = bus.rsp_instr;
                        last_err    = bus.rsp_err;
                        void'(sb.pop_front());
                    end
                end
            end
            if (bus.flush) sb.delete();
            if (bus.req_valid && bus.req_ready) begin
                exp_t e;
                e.err     = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr[31:2] >= 30'(DEPTH));
                e.instr   = e.err ? NOP_WORD : model_mem[bus.req_addr[IW+1:2]];
                e.acc_cyc = cyc;
                e.seen    = 1'b0;
                sb.push_back(e);
                last_acc_cyc = cyc;
            end
            if (bus.wr_en && (bus.wr_addr[31:2] < 30'(DEPTH)))
                model_mem[bus.wr_addr[IW+1:2]] = bus.wr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Holds req_valid until accepted; caller decides whether to drop it.
    task automatic issue(input logic [31:0] addr);
        bit ok;
        ok = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = bus.req_ready;
            tick();
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (hs_cnt < target && n < 30) begin
            tick();
            n++;
        end
        if (hs_cnt < target) check("handshake_timeout", 32'(hs_cnt), 32'(target));
    endtask

    vec_t vecs[7];

    initial begin
        int n0;
        int a0;

        vecs[0] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h00a0_0113, 1'b0};
        vecs[2] = '{32'h0000_0002, NOP_WORD,      1'b1};
        vecs[3] = '{32'h0000_1000, NOP_WORD,      1'b1};
        vecs[4] = '{32'h0000_0003, NOP_WORD,      1'b1};
        vecs[5] = '{32'hFFFF_FFFC, NOP_WORD,      1'b1};
        vecs[6] = '{32'h0000_0FFD, NOP_WORD,      1'b1};

        bus.req_valid = 1'b1;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b1;
        bus.flush     = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;

        // Reset state, with a request held to show it is not taken
        repeat (2) tick();
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_instr", bus.rsp_instr, 32'd0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        tick();
        rst = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        tick();

        // Program load; the out-of-range write must not alias onto word 0
        write_word(32'h0000_0000, 32'h0050_0093);
        write_word(32'h0000_0004, 32'h00a0_0113);
        write_word(32'h0000_1000, 32'hbad0_bad0);

        // Table of single fetches
        for (int i = 0; i < 7; i++) begin
            bus.rsp_ready = 1'b1;
            n0 = hs_cnt;
            issue(vecs[i].addr);
            bus.req_valid = 1'b0;
            wait_hs(n0 + 1);
            check($sformatf("vec%0d_instr", i), last_instr, vecs[i].instr);
            check($sformatf("vec%0d_err", i), 32'(last_err), 32'(vecs[i].err));
        end

        // Back-to-back: second accept lands in the first response cycle
        n0 = hs_cnt;
        issue(32'h0);
        a0 = last_acc_cyc;
        issue(32'h4);
        bus.req_valid = 1'b0;
        check("b2b_accept_spacing", 32'(last_acc_cyc - a0), 32'(LAT));
        wait_hs(n0 + 2);
        check("b2b_second_instr", last_instr, 32'h00a0_0113);
        check("b2b_hs_spacing", 32'(last_hs_cyc - last_acc_cyc), 32'(LAT));

        // Backpressure with a write to the pending word during the stall
        bus.rsp_ready = 1'b0;
        n0 = hs_cnt;
        issue(32'h4);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 10 && !bus.rsp_valid; i++) tick();
        write_word(32'h0000_0004, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_instr", bus.rsp_instr, 32'h00a0_0113);
            check("bp_req_ready", 32'(bus.req_ready), 32'd0);
        end
        tick();
        bus.rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("bp_single_hs", 32'(hs_cnt - n0), 32'd1);
        tick();

        // Flush during WAIT, new request the next cycle
        n0 = hs_cnt;
        issue(32'h4);
        bus.req_valid = 1'b0;
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush_req_ready", 32'(bus.req_ready), 32'd0);
        tick();
        bus.flush = 1'b0;
        issue(32'h0);
        bus.req_valid = 1'b0;
        wait_hs(n0 + 1);
        check("flush_next_instr", last_instr, 32'h0050_0093);
        repeat (3) tick();
        check("flush_hs_count", 32'(hs_cnt - n0), 32'd1);

        // Same-cycle write and accept to word 0: old word returned
        n0 = hs_cnt;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 32'h0;
        bus.wr_data = 32'hdead_beef;
        issue(32'h0);
        bus.req_valid = 1'b0;
        bus.wr_en = 1'b0;
        wait_hs(n0 + 1);
        check("rbw_old_word", last_instr, 32'h0050_0093);
        issue(32'h0);
        bus.req_valid = 1'b0;
        wait_hs(n0 + 2);
        check("rbw_new_word", last_instr, 32'hdead_beef);
        issue(32'h4);
        bus.req_valid = 1'b0;
        wait_hs(n0 + 3);
        check("stall_write_visible", last_instr, 32'h1234_5678);

        // Reset in WAIT abandons the fetch
        n0 = hs_cnt;
        issue(32'h4);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_wait_req_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_wait_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        check("rst_wait_hs_count", 32'(hs_cnt - n0), 32'd0);

        tick();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish before timeout");
        $fatal(1);
    end

endmodule
